// File: rtl/regfile_dump_pkg.sv
// Shared types and widths for the register-file dump engine.
// Widths match the regfile and single-cycle datapath.
package regfile_dump_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned REG_NUM    = 1 << REG_ADDR_W;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StSend = 2'd2,
    StDone = 2'd3
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_if.sv
// Control, regfile read port and output stream of the dump engine.
// master = dump engine; slave = controller, regfile and consumer.
interface regfile_dump_if
  import regfile_dump_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned DATA_W = REG_DATA_W
) ();

  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] first_reg;
  logic [ADDR_W-1:0] last_reg;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              busy;
  logic              done;

  modport master (
    input  start, abort, first_reg, last_reg, rd_data, out_ready,
    output rd_addr, out_valid, out_data, out_index, busy, done
  );

  modport slave (
    output start, abort, first_reg, last_reg, rd_data, out_ready,
    input  rd_addr, out_valid, out_data, out_index, busy, done
  );

endinterface

// File: rtl/regfile_dump.sv
// Walks a wrapping register index range through one combinational regfile read port
// and streams (index, word) pairs over valid/ready, one word per two cycles.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int unsigned NUM_REGS = REG_NUM,
  parameter int unsigned ADDR_W   = REG_ADDR_W,
  parameter int unsigned DATA_W   = REG_DATA_W
) (
  input  logic           clk,
  input  logic           rst_n,
  regfile_dump_if.master bus
);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_index_q, out_index_d;
  logic              busy_q, done_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          idx_d   = bus.first_reg;
          last_d  = bus.last_reg;
          state_d = StLoad;
        end
      end
      StLoad: begin
        out_data_d  = bus.rd_data;
        out_index_d = idx_q;
        out_valid_d = 1'b1;
        state_d     = StSend;
      end
      StSend: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          if (idx_q == last_q) begin
            state_d = StDone;
          end else begin
            idx_d   = (idx_q == ADDR_W'(NUM_REGS - 1)) ? '0 : idx_q + ADDR_W'(1);
            state_d = StLoad;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort wins over a same-cycle handshake; the word in flight still counts as sent.
    if (bus.abort && state_q != StIdle) begin
      state_d     = StIdle;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      last_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      busy_q      <= (state_d == StLoad) || (state_d == StSend);
      done_q      <= (state_d == StDone);
    end
  end

  always_comb begin
    bus.rd_addr = '0;
    if (state_q == StLoad || state_q == StSend) begin
      bus.rd_addr = idx_q;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_index = out_index_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: clocked regfile model, scoreboard of expected words.
module tb_regfile_dump;
  import regfile_dump_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_dump_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  regfile_dump #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Regfile model: combinational read, clocked write.
  logic [31:0] regs   [32] = '{default: 32'd0};
  logic [31:0] shadow [32] = '{default: 32'd0};
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  always @(posedge clk) if (we) regs[wa] <= wd;
  assign bus.rd_data = regs[bus.rd_addr];

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Handshake completes at the next rising edge; compare against scoreboard head.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_word", 64'(sb_q.size()), 64'd1);
      end else begin
        check("sb_word", {27'd0, bus.out_index, bus.out_data}, sb_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rf_write(input int a, input logic [31:0] d);
    we = 1'b1; wa = 5'(a); wd = d;
    tick();
    we = 1'b0;
    shadow[a] = d;
  endtask

  task automatic do_start(input int first, input int last);
    int i;
    i = first;
    while (1) begin
      sb_q.push_back({27'd0, 5'(i), shadow[i]});
      if (i == last) break;
      i = (i + 1) % 32;
    end
    bus.start = 1'b1; bus.first_reg = 5'(first); bus.last_reg = 5'(last);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int cyc;
    cyc = 0;
    while (!bus.done && cyc < max_cyc) begin
      tick();
      cyc++;
    end
    check("done_seen", 64'(bus.done), 64'd1);
    tick();
    check("done_one_cycle", 64'(bus.done), 64'd0);
    check("idle_after_done", 64'(bus.busy), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_data"},  64'(bus.out_data),  64'd0);
    check({tag, "_index"}, 64'(bus.out_index), 64'd0);
    check({tag, "_busy"},  64'(bus.busy),      64'd0);
    check({tag, "_done"},  64'(bus.done),      64'd0);
    check({tag, "_rdaddr"}, 64'(bus.rd_addr),  64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_data;
    logic [4:0]  held_idx;
    int          seen;

    rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.first_reg = '0; bus.last_reg = '0;
    bus.out_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    check_all_zero("reset");

    // Basic dump with exact word timing.
    rf_write(1, 32'h1111_1111);
    rf_write(2, 32'h2222_2222);
    rf_write(3, 32'h3333_3333);
    do_start(1, 3);
    check("basic_busy_e0", 64'(bus.busy), 64'd1);
    check("basic_valid_e0", 64'(bus.out_valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("basic_valid_odd", 64'(bus.out_valid), 64'd1);
      check("basic_index", 64'(bus.out_index), 64'(k + 1));
      tick();
      check("basic_valid_even", 64'(bus.out_valid), 64'd0);
    end
    check("basic_done_e6", 64'(bus.done), 64'd1);
    tick();
    check("basic_done_e7", 64'(bus.done), 64'd0);
    check("basic_busy_e7", 64'(bus.busy), 64'd0);

    // Backpressure on word 2.
    do_start(1, 3);
    tick(); tick(); tick();
    check("bp_word2_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b0;
    held_data = bus.out_data;
    held_idx  = bus.out_index;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_valid_hold", 64'(bus.out_valid), 64'd1);
      check("bp_data_hold", 64'(bus.out_data), 64'(held_data));
      check("bp_index_hold", 64'(bus.out_index), 64'(held_idx));
      check("bp_rdaddr_hold", 64'(bus.rd_addr), 64'd2);
    end
    bus.out_ready = 1'b1;
    wait_done(20);

    // Wrap-around 30 -> 1, including r0.
    rf_write(30, 32'hAAAA_0030);
    rf_write(31, 32'hAAAA_0031);
    rf_write(1,  32'hAAAA_0001);
    do_start(30, 1);
    wait_done(20);
    check("wrap_drained", 64'(sb_q.size()), 64'd0);

    // Abort together with a handshake on word 2.
    do_start(1, 3);
    tick(); tick(); tick();
    check("abort_word2_valid", 64'(bus.out_valid), 64'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_valid", 64'(bus.out_valid), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_left", 64'(sb_q.size()), 64'd1);
    sb_q.delete();
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      seen |= int'(bus.done);
      tick();
    end
    check("abort_no_done", 64'(seen), 64'd0);
    do_start(1, 3);
    wait_done(20);

    // Reset during LOAD, then immediate restart.
    do_start(1, 3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_all_zero("rst_mid");
    sb_q.delete();
    do_start(2, 2);
    check("rst_restart_busy", 64'(bus.busy), 64'd1);
    wait_done(10);

    // Write to r5 on its LOAD capture edge returns the old value.
    rf_write(5, 32'h0000_0005);
    do_start(5, 5);
    we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
    tick();
    we = 1'b0;
    shadow[5] = 32'hDEAD_BEEF;
    check("collide_old", 64'(bus.out_data), 64'h0000_0005);
    wait_done(10);
    do_start(5, 5);
    wait_done(10);

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
